// File: rtl/window_generator_pkg.sv
// -----------------------------------------------------------------------------
// window_generator_pkg
// Shared definitions for the sliding-window generator:
//   - addr_width(): width needed to hold a column (or row) index 0..N
//   - win_bit():    flat bit position of window element (row r, column c)
//   - MinWindowSize: smallest legal window edge
// -----------------------------------------------------------------------------
package window_generator_pkg;

    localparam int MinWindowSize = 3;

    // Width of a counter/address able to represent 0..count.
    function automatic int addr_width(input int count);
        return $clog2(count + 1);
    endfunction

    // Window bit r*n+c: r=0 oldest row, c=0 oldest column.
    function automatic int win_bit(input int r, input int c, input int n);
        return (r * n) + c;
    endfunction

endpackage

// File: rtl/window_generator_if.sv
// -----------------------------------------------------------------------------
// window_generator_if
// Bundles the pixel stream input, the external line-buffer port and the
// window result of window_generator.
//   master : pixel source / line-buffer owner / window consumer
//   slave  : window_generator itself
// Signals:
//   PixelValid, Pixel, FrameStart : raster pixel stream
//   LbWriteEnable, LbAddr, LbData : line-buffer write port (combinational)
//   LbLineData                    : line-buffer async read data, bit n-2 = row y-1
//   Window, WindowValid, FrameDone: registered window result
// -----------------------------------------------------------------------------
interface window_generator_if #(
    parameter int AddrWidth  = 3,
    parameter int WindowSize = 3
);
    logic                               PixelValid;
    logic                               Pixel;
    logic                               FrameStart;
    logic                               LbWriteEnable;
    logic [AddrWidth-1:0]               LbAddr;
    logic                               LbData;
    logic [WindowSize-2:0]              LbLineData;
    logic [WindowSize*WindowSize-1:0]   Window;
    logic                               WindowValid;
    logic                               FrameDone;

    modport master (
        output PixelValid, Pixel, FrameStart, LbLineData,
        input  LbWriteEnable, LbAddr, LbData, Window, WindowValid, FrameDone
    );

    modport slave (
        input  PixelValid, Pixel, FrameStart, LbLineData,
        output LbWriteEnable, LbAddr, LbData, Window, WindowValid, FrameDone
    );
endinterface

// File: rtl/window_generator_raster_counter.sv
// -----------------------------------------------------------------------------
// window_generator_raster_counter
// Column/row counters indexing the current raster pixel.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   pixel_valid   : advance the position on this cycle
//   frame_start   : current pixel is (0,0); alone it just clears the counters
//   cur_x, cur_y  : coordinates of the pixel presented this cycle
//   last_pixel    : current pixel is (ImageWidth-1, ImageHeight-1)
// -----------------------------------------------------------------------------
module window_generator_raster_counter
    import window_generator_pkg::*;
#(
    parameter int ImageWidth  = 7,
    parameter int ImageHeight = 7,
    parameter int XWidth      = 3,
    parameter int YWidth      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pixel_valid,
    input  logic              frame_start,
    output logic [XWidth-1:0] cur_x,
    output logic [YWidth-1:0] cur_y,
    output logic              last_pixel
);

    localparam logic [XWidth-1:0] XLast = XWidth'(ImageWidth - 1);
    localparam logic [YWidth-1:0] YLast = YWidth'(ImageHeight - 1);
    localparam logic [XWidth-1:0] XOne  = XWidth'(1);
    localparam logic [YWidth-1:0] YOne  = YWidth'(1);
    localparam logic [XWidth-1:0] XZero = {XWidth{1'b0}};
    localparam logic [YWidth-1:0] YZero = {YWidth{1'b0}};

    logic [XWidth-1:0] x_r;
    logic [YWidth-1:0] y_r;
    logic [XWidth-1:0] cur_x_s;
    logic [YWidth-1:0] cur_y_s;
    logic [XWidth-1:0] nxt_x_s;
    logic [YWidth-1:0] nxt_y_s;
    logic              last_x_s;
    logic              last_y_s;

    // Current position: FrameStart forces (0,0) irrespective of the counters.
    always_comb begin
        if (frame_start) begin
            cur_x_s = XZero;
            cur_y_s = YZero;
        end else begin
            cur_x_s = x_r;
            cur_y_s = y_r;
        end
    end

    assign last_x_s = (cur_x_s == XLast);
    assign last_y_s = (cur_y_s == YLast);

    // Next position: advance with wrap on a valid pixel, clear on a bare
    // FrameStart, hold otherwise.
    always_comb begin
        nxt_x_s = x_r;
        nxt_y_s = y_r;
        if (pixel_valid) begin
            if (last_x_s) begin
                nxt_x_s = XZero;
                if (last_y_s) begin
                    nxt_y_s = YZero;
                end else begin
                    nxt_y_s = cur_y_s + YOne;
                end
            end else begin
                nxt_x_s = cur_x_s + XOne;
                nxt_y_s = cur_y_s;
            end
        end else if (frame_start) begin
            nxt_x_s = XZero;
            nxt_y_s = YZero;
        end else begin
            nxt_x_s = x_r;
            nxt_y_s = y_r;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= XZero;
            y_r <= YZero;
        end else begin
            x_r <= nxt_x_s;
            y_r <= nxt_y_s;
        end
    end

    assign cur_x      = cur_x_s;
    assign cur_y      = cur_y_s;
    assign last_pixel = last_x_s & last_y_s;

endmodule

// File: rtl/window_generator.sv
// -----------------------------------------------------------------------------
// window_generator
// Builds an n x n binary neighbourhood from a raster pixel stream using an
// external (n-1)-row line buffer.
// Ports:
//   Clock  : single clock, rising edge
//   nReset : asynchronous active-low reset
//   bus    : window_generator_if.slave (pixel stream, line-buffer port,
//            Window / WindowValid / FrameDone results)
// The line buffer is read asynchronously at LbAddr and written on the same
// edge that captures its read data, so the window sees the old column
// contents (rows y-1 .. y-(n-1)) while the new pixel replaces them.
// -----------------------------------------------------------------------------
module window_generator
    import window_generator_pkg::*;
#(
    parameter int ImageWidth  = 7,
    parameter int ImageHeight = 7,
    parameter int WindowSize  = 3
) (
    input  logic               Clock,
    input  logic               nReset,
    window_generator_if.slave  bus
);

    localparam int AddrWidth = addr_width(ImageWidth);
    localparam int YWidth    = addr_width(ImageHeight);
    localparam int WinBits   = WindowSize * WindowSize;

    localparam logic [AddrWidth-1:0] XFirstFull = AddrWidth'(WindowSize - 1);
    localparam logic [YWidth-1:0]    YFirstFull = YWidth'(WindowSize - 1);

    logic [AddrWidth-1:0] cur_x_s;
    logic [YWidth-1:0]    cur_y_s;
    logic                 last_pixel_s;
    logic                 full_s;
    logic [WinBits-1:0]   win_nxt_s;
    logic [WinBits-1:0]   win_r;
    logic                 win_valid_r;
    logic                 frame_done_r;

    window_generator_raster_counter #(
        .ImageWidth  (ImageWidth),
        .ImageHeight (ImageHeight),
        .XWidth      (AddrWidth),
        .YWidth      (YWidth)
    ) u_raster_counter (
        .clk         (Clock),
        .rst_n       (nReset),
        .pixel_valid (bus.PixelValid),
        .frame_start (bus.FrameStart),
        .cur_x       (cur_x_s),
        .cur_y       (cur_y_s),
        .last_pixel  (last_pixel_s)
    );

    // Line-buffer write port follows the pixel stream directly.
    assign bus.LbWriteEnable = bus.PixelValid;
    assign bus.LbAddr        = cur_x_s;
    assign bus.LbData        = bus.Pixel;

    // The window only covers image pixels once n-1 rows and columns precede
    // the current pixel; stale line-buffer rows and previous-row tails are
    // hidden by this flag alone.
    assign full_s = (cur_x_s >= XFirstFull) && (cur_y_s >= YFirstFull);

    // Window shift: every column moves one step older; the newest column is
    // the line-buffer column with the live pixel as the newest row.
    always_comb begin
        win_nxt_s = win_r;
        if (bus.PixelValid) begin
            for (int r = 0; r < WindowSize; r++) begin
                for (int c = 0; c < WindowSize; c++) begin
                    if (c < WindowSize - 1) begin
                        win_nxt_s[win_bit(r, c, WindowSize)] = win_r[win_bit(r, c + 1, WindowSize)];
                    end else if (r < WindowSize - 1) begin
                        win_nxt_s[win_bit(r, c, WindowSize)] = bus.LbLineData[r];
                    end else begin
                        win_nxt_s[win_bit(r, c, WindowSize)] = bus.Pixel;
                    end
                end
            end
        end else begin
            win_nxt_s = win_r;
        end
    end

    // Window register plus its registered qualifiers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            win_r        <= {WinBits{1'b0}};
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            win_r        <= win_nxt_s;
            win_valid_r  <= bus.PixelValid & full_s;
            frame_done_r <= bus.PixelValid & last_pixel_s;
        end
    end

    assign bus.Window      = win_r;
    assign bus.WindowValid = win_valid_r;
    assign bus.FrameDone   = frame_done_r;

endmodule

// File: tb/tb_window_generator.sv
// -----------------------------------------------------------------------------
// tb_window_generator
// Scoreboard bench for window_generator (7x7 image, 3x3 window) with a
// behavioural line buffer. Expected windows are computed from the bench's own
// image array and queued as pixels are sent; a negedge monitor pops them.
// -----------------------------------------------------------------------------
module tb_window_generator;

    localparam int W  = 7;
    localparam int H  = 7;
    localparam int N  = 3;
    localparam int AW = 3;
    localparam int NB = N * N;

    typedef struct packed {
        logic [NB-1:0] win;
        logic          fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    int checks   = 0;
    int failures = 0;
    int win_cnt  = 0;
    int fd_cnt   = 0;

    logic   pend_vld = 1'b0;
    logic   pend_fd  = 1'b0;
    logic   mon_en   = 1'b0;
    exp_t   sb_q[$];
    logic   img [0:H-1][0:W-1];
    logic [N-2:0] lb_mem [0:W];

    always #5 clk = ~clk;

    window_generator_if #(.AddrWidth(AW), .WindowSize(N)) bus();

    window_generator #(
        .ImageWidth  (W),
        .ImageHeight (H),
        .WindowSize  (N)
    ) dut (
        .Clock  (clk),
        .nReset (rst_n),
        .bus    (bus.slave)
    );

    // Behavioural line buffer: async read, write shifts the column history.
    assign bus.LbLineData = lb_mem[bus.LbAddr];
    always @(posedge clk) begin
        if (bus.LbWriteEnable) begin
            lb_mem[bus.LbAddr] <= {bus.LbData, lb_mem[bus.LbAddr][N-2:1]};
        end
    end

    // Monitor: qualifier timing each cycle, window contents from the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.WindowValid !== pend_vld || bus.FrameDone !== pend_fd) begin
                failures++;
                $display("FAIL qualifiers: got valid=%b done=%b, want valid=%b done=%b at %0t",
                         bus.WindowValid, bus.FrameDone, pend_vld, pend_fd, $time);
            end
            if (bus.WindowValid === 1'b1) begin
                win_cnt++;
                if (bus.FrameDone === 1'b1) fd_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL window_unexpected: got %h, want no window", bus.Window);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (bus.Window !== e.win) begin
                        failures++;
                        $display("FAIL window: got %h, want %h at %0t", bus.Window, e.win, $time);
                    end
                end
            end
        end
    end

    function automatic logic [NB-1:0] model_win(input int x, input int y);
        logic [NB-1:0] w;
        w = {NB{1'b0}};
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                w[r*N + c] = img[y - (N-1) + r][x - (N-1) + c];
        return w;
    endfunction

    // One clock edge; declares what the monitor should see after it.
    task automatic step(input logic vld, input logic fd);
        @(posedge clk);
        pend_vld = vld;
        pend_fd  = fd;
        #1;
    endtask

    task automatic send_pix(input int x, input int y, input logic fs, input int gaps);
        logic ok;
        logic last;
        exp_t e;
        for (int i = 0; i < gaps; i++) step(1'b0, 1'b0);
        bus.PixelValid = 1'b1;
        bus.Pixel      = img[y][x];
        bus.FrameStart = fs;
        #1;
        checks++;
        if (bus.LbAddr !== AW'(x) || bus.LbWriteEnable !== 1'b1 || bus.LbData !== img[y][x]) begin
            failures++;
            $display("FAIL lb_port: got addr=%0d we=%b data=%b, want addr=%0d we=1 data=%b",
                     bus.LbAddr, bus.LbWriteEnable, bus.LbData, x, img[y][x]);
        end
        ok   = (x >= N-1) && (y >= N-1);
        last = (x == W-1) && (y == H-1);
        if (ok) begin
            e.win = model_win(x, y);
            e.fd  = last;
            sb_q.push_back(e);
        end
        step(ok, last);
        bus.PixelValid = 1'b0;
        bus.FrameStart = 1'b0;
    endtask

    // Send pixels in raster order up to index stop (y*W+x), optional gaps.
    task automatic send_frame(input logic fs, input logic gaps, input int stop);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (y*W + x <= stop)
                    send_pix(x, y, fs && (x == 0) && (y == 0),
                             gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic check_counts(input string name, input int w0, input int f0,
                                input int wexp, input int fexp);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if ((win_cnt - w0) != wexp || (fd_cnt - f0) != fexp) begin
            failures++;
            $display("FAIL %s: got windows=%0d done=%0d, want windows=%0d done=%0d",
                     name, win_cnt - w0, fd_cnt - f0, wexp, fexp);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (bus.Window !== {NB{1'b0}} || bus.WindowValid !== 1'b0 ||
            bus.FrameDone !== 1'b0 || bus.LbAddr !== {AW{1'b0}}) begin
            failures++;
            $display("FAIL %s: got win=%h valid=%b done=%b addr=%0d, want 0 0 0 0",
                     name, bus.Window, bus.WindowValid, bus.FrameDone, bus.LbAddr);
        end
    endtask

    task automatic fill(input int mode);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (mode)
                    0:       img[y][x] = 1'b1;
                    1:       img[y][x] = (x == 3 && y == 3);
                    2:       img[y][x] = (((x * 5) + (y * 3)) % 4) == 0;
                    default: img[y][x] = (((x * 3) + (y * 7) + 1) % 3) != 0;
                endcase
    endtask

    initial begin
        int w0;
        int f0;
        for (int i = 0; i <= W; i++) lb_mem[i] = {(N-1){1'b0}};
        bus.PixelValid = 1'b0;
        bus.Pixel      = 1'b0;
        bus.FrameStart = 1'b0;
        rst_n          = 1'b0;
        #22;
        check_reset("reset_state");
        rst_n = 1'b1;
        mon_en = 1'b1;
        step(1'b0, 1'b0);

        // All-ones frame, gapless.
        fill(0);
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(1'b1, 1'b0, W*H - 1);
        check_counts("all_ones_counts", w0, f0, 25, 1);

        // Single dot at (3,3).
        fill(1);
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(1'b1, 1'b0, W*H - 1);
        check_counts("dot_counts", w0, f0, 25, 1);

        // Pattern with random idle gaps.
        fill(2);
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(1'b1, 1'b1, W*H - 1);
        check_counts("gaps_counts", w0, f0, 25, 1);

        // Reset after pixel (4,2), then a fresh FrameStart frame.
        fill(3);
        send_frame(1'b1, 1'b0, 2*W + 4);
        step(1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset("midframe_reset");
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(1'b1, 1'b1, W*H - 1);
        check_counts("after_reset_counts", w0, f0, 25, 1);

        // Partial frame, bare FrameStart clears position, then frame w/o FrameStart.
        fill(2);
        send_frame(1'b0, 1'b0, W + 3);
        bus.FrameStart = 1'b1;
        step(1'b0, 1'b0);
        bus.FrameStart = 1'b0;
        fill(0);
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(1'b0, 1'b0, W*H - 1);
        check_counts("bare_fs_counts", w0, f0, 25, 1);

        // Two back-to-back frames, second starts implicitly.
        fill(3);
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(1'b1, 1'b0, W*H - 1);
        fill(1);
        send_frame(1'b0, 1'b0, W*H - 1);
        check_counts("back_to_back_counts", w0, f0, 50, 2);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 SHALL have parameter ImageWidth, default 7, pixels per row.
REQ-002 SHALL have parameter ImageHeight, default 7, rows per frame.
REQ-003 SHALL have parameter WindowSize, default 3, window edge n (odd, >=3).
REQ-004 SHALL derive local AddrWidth = $clog2(ImageWidth+1).
REQ-005 Clock  input  1  single clock; all state on rising edge.
REQ-006 nReset  input  1  asynchronous, active-low reset.
REQ-007 PixelValid  input  1  Pixel carries a valid sample this cycle.
REQ-008 Pixel  input  1  binary pixel, raster order.
REQ-009 FrameStart  input  1  marks first pixel of a frame.
REQ-010 LbWriteEnable  output  1  line-buffer write strobe.
REQ-011 LbAddr  output  AddrWidth  line-buffer column address.
REQ-012 LbData  output  1  pixel written into line buffer.
REQ-013 LbLineData  input  n-1  line-buffer read data; bit n-2 = row y-1, bit 0 = row y-(n-1).
REQ-014 Window  output  n*n  bit r*n+c; r=0 oldest row, c=0 oldest column.
REQ-015 WindowValid  output  1  Window holds a fully in-image n x n neighbourhood.
REQ-016 FrameDone  output  1  one-cycle pulse after last pixel of frame.

Function
REQ-017 Column counter x (0..ImageWidth-1) and row counter y (0..ImageHeight-1) SHALL index the current pixel.
REQ-018 LbWriteEnable, LbAddr, LbData SHALL be combinational: PixelValid, x, Pixel.
REQ-019 Line buffer read is asynchronous at LbAddr, write on clock edge; LbLineData SHALL be sampled in the same cycle as the write (read-before-write).
REQ-020 On each valid pixel, window SHALL shift one column: column c shifts to c-1, new column n-1 = {LbLineData, Pixel}, Pixel in row n-1.
REQ-021 Window registers and counters SHALL hold when PixelValid=0.
REQ-022 Valid pixel SHALL advance x; at x=ImageWidth-1 x wraps to 0 and y increments; at y=ImageHeight-1 y also wraps to 0.
REQ-023 WindowValid SHALL be registered, asserted one cycle after a valid pixel with x>=n-1 and y>=n-1, else 0; latency = 1 cycle.
REQ-024 FrameDone SHALL pulse one cycle after valid pixel (ImageWidth-1, ImageHeight-1), coincident with that WindowValid.
REQ-025 FrameStart with PixelValid SHALL treat that pixel as (0,0) regardless of counters.
REQ-026 FrameStart without PixelValid SHALL clear x, y only; window unchanged.
REQ-027 Window contents at x<n-1 (previous-row tail) are don't-care; WindowValid masks them.
REQ-028 Pixels after wrap without FrameStart SHALL start the next frame implicitly.
REQ-029 Stale line-buffer rows SHALL be masked solely by y; no clearing of line buffer.

Reset
REQ-030 nReset low SHALL immediately clear x, y, Window, WindowValid, FrameDone to 0.
REQ-031 Reset mid-frame SHALL restart at (0,0); no WindowValid before pixel (n-1,n-1) of the new stream.
REQ-032 Line-buffer contents are not reset.

Structure
REQ-033 Shared package SHALL hold helper for AddrWidth and constant for window bit indexing (r*n+c).
REQ-034 One sub-module natural: raster_counter (x/y counters, wrap, FrameStart, last-pixel flag).
REQ-035 Line buffer instantiated beside this block, not inside.

Verification (ImageWidth=7, ImageHeight=7, n=3, line-buffer model attached)
REQ-036 nReset low -> Window=9'h000, WindowValid=0, FrameDone=0, LbAddr=0.
REQ-037 All-ones frame, gapless -> first WindowValid one cycle after 17th pixel (2,2), Window=9'h1FF; 25 valid windows; FrameDone with 25th.
REQ-038 Single 1 at (3,3), rest 0 -> Window nonzero only on windows for pixels (3..5,3..5); at pixel (4,4) Window=9'h010.
REQ-039 Random idle cycles between pixels -> Window/WindowValid sequence identical to gapless run; WindowValid only after valid pixels.
REQ-040 nReset pulse after pixel (4,2), then FrameStart frame -> no WindowValid until pixel (2,2), results match fresh frame.
REQ-041 Two back-to-back frames, second without FrameStart -> LbAddr cycles 0..6, two FrameDone pulses, identical window counts.
